ai_knn_sorter: RTL and testbench

- Collects `(label, distance)` candidates from the template comparer and keeps the 8 smallest distances in an ascending, insertion-sorted list.
- On `flush`, streams the list best-first, one entry per `EMIT_GAP` cycles, in the 32-bit `{flags,label,distance}` word format consumed by the downstream rank-weighted scorer.
- Sits between the per-template distance comparer and the scorer.

---
 rtl/ai_knn_sorter.sv | 177 +++++++++++++++++
 tb/tb_ai_knn_sorter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ai_knn_sorter.sv
// ai_knn_sorter: keeps the DEPTH nearest (label, distance) candidates from the
// template comparer in an ascending, insertion-sorted list. On flush, the list
// is streamed best-first to the rank-weighted scorer. Each word is sent
// EMIT_GAP cycles after the previous one.
// Optional feature macro: AI_KNN_TIE_NEWER_EN. When it is defined, a candidate
// with a distance equal to an existing entry is placed ahead of that entry.
module ai_knn_sorter #(
  parameter int DEPTH    = 8,
  parameter int EMIT_GAP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        cand_valid,
  input  logic [2:0]  cand_label,
  input  logic [23:0] cand_dist,
  output logic        cand_ready,
  input  logic        flush,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        busy,
  output logic        done
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(EMIT_GAP);
  localparam logic [IW-1:0] LAST_IDX   = IW'(DEPTH - 1);
  localparam logic [CW-1:0] GAP_END    = CW'(EMIT_GAP - 2);
  localparam logic [31:0]   EMPTY_WORD = 32'h08FF_FFFF;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_EMIT,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt;

  logic [DEPTH-1:0] slot_vld;
  logic [2:0]       slot_label [DEPTH];
  logic [23:0]      slot_dist  [DEPTH];

  logic [DEPTH-1:0] below_vld;
  logic [2:0]       below_label [DEPTH];
  logic [23:0]      below_dist  [DEPTH];

  logic [DEPTH-1:0] ins_vld;
  logic [2:0]       ins_label [DEPTH];
  logic [23:0]      ins_dist  [DEPTH];

  logic [DEPTH-1:0] qual;
  logic             prev_q;
  logic             accept;

  // cand_ready is only ever high in COLLECT, so this also gates on state
  assign accept = cand_valid & cand_ready;

  // Per-slot test: the candidate belongs at or above this slot
  always_comb begin
    qual = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef AI_KNN_TIE_NEWER_EN
      qual[i] = !slot_vld[i] || (cand_dist <= slot_dist[i]);
`else
      qual[i] = !slot_vld[i] || (cand_dist < slot_dist[i]);
`endif
    end
  end

  // Each slot's upper neighbour, used as the shift-down source
  always_comb begin
    below_vld      = '0;
    below_label[0] = '0;
    below_dist[0]  = '0;
    for (int i = 1; i < DEPTH; i++) begin
      below_vld[i]   = slot_vld[i-1];
      below_label[i] = slot_label[i-1];
      below_dist[i]  = slot_dist[i-1];
    end
  end

  // Next list contents: candidate at the first qualifying slot, the rest shift down
  always_comb begin
    ins_vld   = slot_vld;
    ins_label = slot_label;
    ins_dist  = slot_dist;
    prev_q    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (qual[i]) begin
        if (!prev_q) begin
          ins_vld[i]   = 1'b1;
          ins_label[i] = cand_label;
          ins_dist[i]  = cand_dist;
        end else begin
          ins_vld[i]   = below_vld[i];
          ins_label[i] = below_label[i];
          ins_dist[i]  = below_dist[i];
        end
      end
      prev_q = qual[i];
    end
  end

  // Control FSM: list update, emission sequencing and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_COLLECT;
      idx        <= '0;
      cnt        <= '0;
      slot_vld   <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cand_ready <= 1'b0;
    end else if (init) begin
      state      <= S_COLLECT;
      idx        <= '0;
      cnt        <= '0;
      slot_vld   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cand_ready <= 1'b1;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (accept) begin
        slot_vld   <= ins_vld;
        slot_label <= ins_label;
        slot_dist  <= ins_dist;
      end
      case (state)
        S_COLLECT: begin
          cand_ready <= 1'b1;
          if (flush) begin
            state      <= S_EMIT;
            idx        <= '0;
            busy       <= 1'b1;
            cand_ready <= 1'b0;
          end
        end
        S_EMIT: begin
          out_valid <= 1'b1;
          out_data  <= slot_vld[idx] ? {4'b0, 1'b0, slot_label[idx], slot_dist[idx]}
                                     : EMPTY_WORD;
          cnt       <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == GAP_END) begin
            if (idx == LAST_IDX) begin
              state <= S_FINISH;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_EMIT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FINISH: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          slot_vld   <= '0;
          cand_ready <= 1'b0;
          state      <= S_COLLECT;
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_ai_knn_sorter.sv
// tb_ai_knn_sorter: directed plus randomized checks of ai_knn_sorter.
// The reference model keeps all accepted candidates. At flush it selects the
// DEPTH best by (distance, arrival order). The compare process checks the
// strobe, done, busy and ready timing on every cycle.
module tb_ai_knn_sorter;

  localparam int DEPTH = 8;
  localparam int GAP   = 4;
  localparam int SPAN  = DEPTH * GAP;
  localparam logic [31:0] EMPTY_WORD = 32'h08FF_FFFF;

  logic        clk = 1'b0;
  logic        rst, init, cand_valid, flush;
  logic [2:0]  cand_label;
  logic [23:0] cand_dist;
  logic        cand_ready, out_valid, busy, done;
  logic [31:0] out_data;

  int  n_pass = 0;
  int  n_total = 0;
  int  cyc = 0;
  bit  chk_en = 1'b0;
  bit  accepting = 1'b0;
  int  flush_cyc = -1;
  int  abort_cyc = 1 << 30;
  logic [31:0] exp_words [DEPTH];
  logic [31:0] cap [DEPTH];
  int  q_dist[$];
  int  q_label[$];

  ai_knn_sorter #(.DEPTH(DEPTH), .EMIT_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .init(init),
    .cand_valid(cand_valid), .cand_label(cand_label), .cand_dist(cand_dist),
    .cand_ready(cand_ready), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Cycle counter: value n means edge n has happened
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp_v);
  endtask

  // Best DEPTH candidates by distance; ties resolved by arrival order
  function automatic void build_expected();
    bit taken[$];
    for (int j = 0; j < q_dist.size(); j++) taken.push_back(1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      int best;
      best = -1;
      for (int j = 0; j < q_dist.size(); j++) begin
        if (!taken[j]) begin
          if (best < 0) best = j;
`ifdef AI_KNN_TIE_NEWER_EN
          else if (q_dist[j] <= q_dist[best]) best = j;
`else
          else if (q_dist[j] < q_dist[best]) best = j;
`endif
        end
      end
      if (best >= 0) begin
        taken[best] = 1'b1;
        exp_words[k] = {4'b0, 1'b0, 3'(q_label[best]), 24'(q_dist[best])};
      end else begin
        exp_words[k] = EMPTY_WORD;
      end
    end
  endfunction

  // Per-cycle comparison of all outputs against the emission schedule
  always @(negedge clk) begin
    int  rel, k;
    bit  ev, ed;
    if (chk_en) begin
      ev = 1'b0; ed = 1'b0; k = 0; rel = -1;
      if (flush_cyc >= 0) rel = cyc - flush_cyc;
      if (flush_cyc >= 0 && cyc < abort_cyc) begin
        if (rel >= 1 && (rel - 1) % GAP == 0 && (rel - 1) / GAP < DEPTH) begin
          ev = 1'b1;
          k  = (rel - 1) / GAP;
        end
        if (rel == SPAN + 1) ed = 1'b1;
        if (rel >= 1 && rel <= SPAN) check_output("busy_during_emit", 32'(busy), 32'd1);
        if (rel == SPAN + 1) check_output("busy_at_done", 32'(busy), 32'd0);
        if (rel >= 0 && rel <= SPAN + 1) check_output("ready_during_emit", 32'(cand_ready), 32'd0);
        if (rel == SPAN + 2) check_output("ready_after_done", 32'(cand_ready), 32'd1);
      end
      if (cyc == abort_cyc) begin
        check_output("ready_after_init", 32'(cand_ready), 32'd1);
        check_output("busy_after_init", 32'(busy), 32'd0);
      end
      check_output("out_valid", 32'(out_valid), 32'(ev));
      check_output("done", 32'(done), 32'(ed));
      if (ev) begin
        check_output($sformatf("out_data[%0d]", k), out_data, exp_words[k]);
        cap[k] = out_data;
      end
    end
  end

  task automatic apply_stimulus(input bit v, input bit f, input int lbl, input int d);
    @(negedge clk);
    cand_valid = v;
    flush      = f;
    cand_label = lbl[2:0];
    cand_dist  = d[23:0];
    if (v && accepting) begin
      q_dist.push_back(d & 32'hFF_FFFF);
      q_label.push_back(lbl & 7);
    end
    if (f && accepting) begin
      build_expected();
      q_dist.delete();
      q_label.delete();
      flush_cyc = cyc + 1;
      abort_cyc = 1 << 30;
      accepting = 1'b0;
    end
  endtask

  task automatic finish_emission();
    apply_stimulus(1'b0, 1'b0, 0, 0);
    while (cyc < flush_cyc + SPAN + 2) @(negedge clk);
    accepting = 1'b1;
  endtask

  task automatic do_init();
    @(negedge clk);
    init = 1'b1; cand_valid = 1'b0; flush = 1'b0;
    q_dist.delete();
    q_label.delete();
    abort_cyc = cyc + 1;
    accepting = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  initial begin
    int n, lbl, d;
    rst = 1'b1; init = 1'b0; cand_valid = 1'b0; flush = 1'b0;
    cand_label = '0; cand_dist = '0;
    repeat (3) @(negedge clk);
    check_output("reset_out_data", out_data, 32'd0);
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_ready", 32'(cand_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_output("ready_after_reset", 32'(cand_ready), 32'd1);
    accepting = 1'b1;
    chk_en = 1'b1;

    $display("[TB] empty flush");
    apply_stimulus(1'b0, 1'b1, 0, 0);
    finish_emission();
    check_output("empty_word0", cap[0], 32'h08FF_FFFF);
    check_output("empty_word7", cap[7], 32'h08FF_FFFF);

    $display("[TB] sorting");
    apply_stimulus(1'b1, 1'b0, 0, 50);
    apply_stimulus(1'b1, 1'b0, 1, 10);
    apply_stimulus(1'b1, 1'b0, 2, 30);
    apply_stimulus(1'b1, 1'b0, 3, 20);
    apply_stimulus(1'b1, 1'b0, 4, 40);
    apply_stimulus(1'b0, 1'b1, 0, 0);
    finish_emission();
    check_output("sort_word0", cap[0], 32'h0100_000A);
    check_output("sort_word1", cap[1], 32'h0300_0014);
    check_output("sort_word2", cap[2], 32'h0200_001E);
    check_output("sort_word4", cap[4], 32'h0000_0032);
    check_output("sort_word5", cap[5], 32'h08FF_FFFF);

    $display("[TB] overflow");
    for (int i = 0; i < 12; i++) apply_stimulus(1'b1, 1'b0, i, 12 - i);
    apply_stimulus(1'b1, 1'b0, 0, 100);
    apply_stimulus(1'b0, 1'b1, 0, 0);
    finish_emission();
    check_output("ovf_word0", cap[0], 32'h0300_0001);
    check_output("ovf_word7", cap[7], 32'h0400_0008);

    $display("[TB] tie");
    apply_stimulus(1'b1, 1'b0, 1, 7);
    apply_stimulus(1'b1, 1'b0, 2, 7);
    apply_stimulus(1'b0, 1'b1, 0, 0);
    finish_emission();
`ifdef AI_KNN_TIE_NEWER_EN
    check_output("tie_word0", cap[0], 32'h0200_0007);
    check_output("tie_word1", cap[1], 32'h0100_0007);
`else
    check_output("tie_word0", cap[0], 32'h0100_0007);
    check_output("tie_word1", cap[1], 32'h0200_0007);
`endif

    $display("[TB] handshake");
    apply_stimulus(1'b1, 1'b0, 6, 9);
    apply_stimulus(1'b1, 1'b0, 7, 3);
    apply_stimulus(1'b0, 1'b1, 0, 0);
    while (cyc < flush_cyc + SPAN) apply_stimulus(1'b1, 1'b0, $urandom_range(0, 7), $urandom_range(0, 2));
    finish_emission();
    check_output("hs_word0", cap[0], 32'h0700_0003);
    check_output("hs_word2", cap[2], 32'h08FF_FFFF);
    apply_stimulus(1'b1, 1'b0, 1, 4);
    apply_stimulus(1'b1, 1'b1, 5, 0);
    finish_emission();
    check_output("hs_flush_word0", cap[0], 32'h0500_0000);
    check_output("hs_flush_word1", cap[1], 32'h0100_0004);

    $display("[TB] abort");
    apply_stimulus(1'b1, 1'b0, 2, 11);
    apply_stimulus(1'b0, 1'b1, 0, 0);
    while (cyc < flush_cyc + 9) apply_stimulus(1'b0, 1'b0, 0, 0);
    do_init();
    repeat (30) apply_stimulus(1'b0, 1'b0, 0, 0);
    apply_stimulus(1'b0, 1'b1, 0, 0);
    finish_emission();
    check_output("abort_word0", cap[0], 32'h08FF_FFFF);

    $display("[TB] random rounds");
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(0, 14);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) apply_stimulus(1'b0, 1'b0, 0, 0);
        lbl = $urandom_range(0, 7);
        d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24'hFF_FFFF)) : int'($urandom_range(0, 15));
        apply_stimulus(1'b1, 1'b0, lbl, d);
      end
      if ($urandom_range(0, 1) == 1) apply_stimulus(1'b1, 1'b1, $urandom_range(0, 7), $urandom_range(0, 15));
      else apply_stimulus(1'b0, 1'b1, 0, 0);
      finish_emission();
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
